adder_rr_scheduler: RTL and testbench
=====================================

Name: adder_rr_scheduler

Overview:
- Shares one WIDTH-bit adder datapath (zero carry-in, sum plus carry-out) among NREQ requesters.
- Each requester presents an operand pair with a valid/ready handshake. A round-robin arbiter picks one pair per cycle.
- The sum, carry and winning requester ID go into a single-entry registered response slot with its own valid/ready handshake.
- Sits between the client blocks and the shared adder; all arithmetic users in the datapath go through it.

Parameters:
- WIDTH, 10, operand and sum width in bits.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the requester ID; must equal ceil(log2(NREQ)).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  bit i: requester i has an operand pair.
- req_ready  output  NREQ  bit i: pair from requester i accepted this cycle.
- req_a  input  NREQ*WIDTH  operand a; requester i in bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand b; same packing as req_a.
- rsp_valid  output  1  response slot holds a result.
- rsp_ready  input  1  consumer takes the result this cycle.
- rsp_sum  output  WIDTH  low WIDTH bits of a+b.
- rsp_cout  output  1  carry-out of a+b.
- rsp_id  output  IDW  index of the requester that produced the result.

Behaviour:
- Reset (async assert, sync release):
  - rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has top priority first.
  - A held result is discarded; no partial response survives reset.
- Slot accept condition: accept = !rsp_valid | rsp_ready. The slot can reload in the same cycle it is drained.
- Grant:
  - Combinational, one-hot.
  - Among req_valid bits, the first set bit searching last+1, last+2, ... modulo NREQ.
  - No valid requests -> no grant.
- Handshake:
  - req_ready[i] = grant[i] & accept. At most one req_ready bit is high per cycle.
  - A transfer occurs when req_valid[i] & req_ready[i].
  - req_ready may depend combinationally on req_valid and rsp_ready. Requesters must not make req_valid depend on req_ready.
- On a transfer from requester i, at the next edge:
  - {rsp_cout, rsp_sum} <= a_i + b_i, computed at WIDTH+1 bits, carry-in 0, no saturation.
  - rsp_id <= i, rsp_valid <= 1, last <= i.
- Without a transfer:
  - If rsp_valid & rsp_ready: rsp_valid <= 0; rsp_sum, rsp_cout and rsp_id hold their values (don't-care to consumers).
  - If rsp_valid & !rsp_ready: the slot holds all fields stable. Every req_ready is 0 and last is unchanged (backpressure).
- Pointer: last changes only on a transfer. An idle cycle or a stall does not rotate priority.
- Latency: 1 cycle from transfer to rsp_valid. Full throughput is 1 result per cycle while rsp_ready=1.
- Fairness: a requester holding req_valid is granted within NREQ transfers.
- Requester obligation: a requester whose req_valid is high keeps its operands stable until req_ready.
- Wrap-around: after a grant to NREQ-1, search restarts at 0. Carry from a+b overflow appears only in rsp_cout; rsp_sum wraps modulo 2^WIDTH.
- Simultaneous events:
  - Drain and reload in the same cycle -> rsp_valid stays 1 with the new data.
  - A request arriving the same cycle the slot frees is granted that cycle.

Test Plan:
- Reset, then a single request: req_valid=0001, a0=0x3FF, b0=0x001, rsp_ready=1 -> req_ready=0001 that cycle; next cycle rsp_valid=1, rsp_sum=0x000, rsp_cout=1, rsp_id=0.
- All four request continuously with rsp_ready=1, a_i=i, b_i=100 -> grants 0,1,2,3,0,... one per cycle; sums 100,101,102,103 with matching IDs, back-to-back with no bubbles.
- Backpressure: slot full with rsp_ready=0 for 5 cycles while req_valid=1111 -> req_ready=0000 and rsp fields stable. On the first cycle rsp_ready=1, the next grant goes to (last+1) and the new data appears on the following cycle.
- Priority hold: last=2, then 3 idle cycles, then req_valid=1001 -> grant requester 3, then requester 0.
- Reset mid-operation: rsp_valid=1 held, assert rst asynchronously (no clock edge) -> rsp_valid=0 immediately. After release with req_valid=0010 -> requester 1 is granted, rsp_id=1.
- Random: 10k cycles of random valids, operands and rsp_ready -> every result equals a+b at 11 bits, with correct ID. No requester waits more than NREQ transfers. At most one req_ready bit high per cycle.

Source files
------------

// File: rtl/adder_rr_scheduler.sv
// adder_rr_scheduler
//   Shares a single WIDTH-bit adder (carry-in 0, sum plus carry-out) among
//   NREQ requesters. A round-robin arbiter picks one operand pair per cycle.
//   The result, its carry and the winning requester ID are held in a
//   single-entry registered response slot with a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   req_valid  [NREQ]        requester i presents an operand pair
//   req_ready  [NREQ]        pair from requester i is taken this cycle
//   req_a      [NREQ*WIDTH]  operand a, requester i at [i*WIDTH +: WIDTH]
//   req_b      [NREQ*WIDTH]  operand b, same packing
//   rsp_valid                response slot holds a result
//   rsp_ready                consumer takes the result this cycle
//   rsp_sum    [WIDTH]       low WIDTH bits of a+b
//   rsp_cout                 carry-out of a+b
//   rsp_id     [IDW]         requester that produced the result
module adder_rr_scheduler #(
  parameter int WIDTH = 10,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic [IDW-1:0]        rsp_id
);

  // Round-robin search: first set bit of v at l+1, l+2, ... modulo NREQ.
  // Returns {found, index}; index is meaningful only when found is set.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v,
                                           input logic [IDW-1:0]  l);
    logic [IDW:0]   r;
    logic [IDW-1:0] cand;
    r = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(l) + k) % NREQ);
      r    = (!r[IDW] && v[cand]) ? {1'b1, cand} : r;
    end
    return r;
  endfunction

  logic [IDW-1:0]  last;      // most recently granted requester
  logic [IDW:0]    pick;
  logic            accept;    // slot can take a new result this cycle
  logic            transfer;
  logic [NREQ-1:0] grant;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH:0]   sum_full;

  // Arbitration and request-side handshake
  always_comb begin
    pick   = rr_pick(req_valid, last);
    accept = ~rsp_valid | rsp_ready;   // slot may drain and reload together
    grant  = '0;
    if (pick[IDW]) begin
      grant[pick[IDW-1:0]] = 1'b1;
    end else begin
      grant = '0;
    end
    req_ready = grant & {NREQ{accept}};
    transfer  = pick[IDW] & accept;
  end

  // Operand mux driven by the one-hot grant, followed by the shared adder
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_sel = grant[i] ? req_a[i*WIDTH +: WIDTH] : a_sel;
      b_sel = grant[i] ? req_b[i*WIDTH +: WIDTH] : b_sel;
    end
    sum_full = {1'b0, a_sel} + {1'b0, b_sel};
  end

  // Response slot and round-robin pointer; the pointer moves only on a transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= '0;
      last      <= IDW'(NREQ - 1);
    end else if (transfer) begin
      rsp_valid <= 1'b1;
      rsp_sum   <= sum_full[WIDTH-1:0];
      rsp_cout  <= sum_full[WIDTH];
      rsp_id    <= pick[IDW-1:0];
      last      <= pick[IDW-1:0];
    end else if (rsp_ready) begin
      // Drained with nothing to reload; data fields keep their old values.
      rsp_valid <= 1'b0;
    end else begin
      // Stalled or idle: everything holds.
      rsp_valid <= rsp_valid;
    end
  end

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Self-checking bench for adder_rr_scheduler: directed cases with literal
// expectations plus a randomized phase checked every cycle against a
// behavioural model of the arbitration, arithmetic and response slot.
module tb_adder_rr_scheduler;
  localparam int WIDTH = 10;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
  logic [IDW-1:0]        rsp_id;

  int nchk = 0;
  int nerr = 0;

  adder_rr_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    nchk = nchk + 1;
    if (act != exp) begin
      nerr = nerr + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  int m_last;
  bit m_valid;
  int m_sum, m_cout, m_id;
  int others [NREQ];   // transfers to other requesters while i has waited

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      m_last  = NREQ - 1;
      m_valid = 1'b0;
      m_sum   = 0;
      m_cout  = 0;
      m_id    = 0;
      for (int i = 0; i < NREQ; i++) others[i] = 0;
    end else begin
      int g;
      bit acc;
      int s;
      int exp_rdy;
      g = -1;
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_last + k) % NREQ;
        if (g < 0 && req_valid[c]) g = c;
      end
      acc = !m_valid || rsp_ready;
      exp_rdy = (g >= 0 && acc) ? (1 << g) : 0;
      check("m_rsp_valid", int'(rsp_valid), int'(m_valid));
      if (m_valid) begin
        check("m_rsp_sum", int'(rsp_sum), m_sum);
        check("m_rsp_cout", int'(rsp_cout), m_cout);
        check("m_rsp_id", int'(rsp_id), m_id);
      end
      check("m_req_ready", int'(req_ready), exp_rdy);
      check("m_onehot", int'($countones(req_ready) <= 1), 1);
      if (g >= 0 && acc) begin
        check("m_fairness", int'(others[g] <= NREQ - 1), 1);
        for (int i = 0; i < NREQ; i++) begin
          if (i == g || !req_valid[i]) others[i] = 0;
          else others[i] = others[i] + 1;
        end
        s = int'(req_a[g*WIDTH +: WIDTH]) + int'(req_b[g*WIDTH +: WIDTH]);
        m_sum   = s % (1 << WIDTH);
        m_cout  = s / (1 << WIDTH);
        m_id    = g;
        m_last  = g;
        m_valid = 1'b1;
      end else if (m_valid && rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] rnd_op();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return {WIDTH{1'b1}};
    else if (r == 1) return '0;
    else return WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
  endfunction

  logic [NREQ-1:0] xfer;

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_valid", int'(rsp_valid), 0);
    check("rst_sum", int'(rsp_sum), 0);
    check("rst_cout", int'(rsp_cout), 0);
    check("rst_id", int'(rsp_id), 0);
    tick();
    rst = 1'b0;

    // Single request with overflow: 0x3FF + 1
    req_valid = 4'b0001;
    req_a[9:0] = 10'h3FF;
    req_b[9:0] = 10'h001;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t1_ready", int'(req_ready), 1);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("t1_valid", int'(rsp_valid), 1);
    check("t1_sum", int'(rsp_sum), 0);
    check("t1_cout", int'(rsp_cout), 1);
    check("t1_id", int'(rsp_id), 0);

    // All four requesting, full throughput
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = WIDTH'(i);
      req_b[i*WIDTH +: WIDTH] = WIDTH'(100);
    end
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t2_ready", int'(req_ready), 1 << (k % 4));
      if (k >= 1) begin
        check("t2_valid", int'(rsp_valid), 1);
        check("t2_sum", int'(rsp_sum), 100 + (k - 1) % 4);
        check("t2_id", int'(rsp_id), (k - 1) % 4);
      end
      tick();
    end

    // Backpressure: slot holds 103 from requester 3
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t3_ready", int'(req_ready), 0);
      check("t3_valid", int'(rsp_valid), 1);
      check("t3_sum", int'(rsp_sum), 103);
      check("t3_id", int'(rsp_id), 3);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t3_release_ready", int'(req_ready), 1);
    tick();
    @(negedge clk);
    check("t3_new_sum", int'(rsp_sum), 100);
    check("t3_new_id", int'(rsp_id), 0);
    tick();

    // Priority hold across idle cycles
    do_reset();
    req_valid = 4'b0100;
    @(negedge clk);
    check("t4_grant2", int'(req_ready), 4);
    tick();
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t4_idle", int'(req_ready), 0);
      tick();
    end
    req_valid = 4'b1001;
    @(negedge clk);
    check("t4_grant3", int'(req_ready), 8);
    tick();
    @(negedge clk);
    check("t4_grant0", int'(req_ready), 1);
    tick();
    req_valid = '0;
    @(negedge clk);
    tick();

    // Asynchronous reset while a result is held
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("t5_ready", int'(req_ready), 1);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("t5_held", int'(rsp_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_clear", int'(rsp_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t5_grant1", int'(req_ready), 2);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("t5_valid", int'(rsp_valid), 1);
    check("t5_id", int'(rsp_id), 1);
    tick();

    // Randomized traffic; requesters hold valid and operands until taken
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      xfer = req_valid & req_ready;
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (xfer[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 1) == 1);
          req_a[i*WIDTH +: WIDTH] = rnd_op();
          req_b[i*WIDTH +: WIDTH] = rnd_op();
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
